k6502_int_ctrl: RTL and testbench
=================================

# k6502_int_ctrl

Parametrised interrupt controller for the k6502 core, generalising the fixed reset/NMI/IRQ sequencer. Latches reset, one NMI and `NUM_IRQ` maskable IRQ channels, each configurable as edge- or level-sensitive. At each opcode-fetch boundary (`sync`) it selects, by fixed priority, which exception the microcode runs next. It drives the `rst`/`nmi`/`irq` qualifiers into `mcode` and the vector low byte `fi` into `data_mux`.

## Interface
Parameters:
- `NUM_IRQ`, 4: number of IRQ channels, 1..8.
- `IRQ_EDGE`, `{NUM_IRQ{1'b0}}`: per-channel mode; bit n = 1 makes channel n falling-edge triggered, 0 makes it level (active-low).
- `IRQ_VEC_BASE`, 8'hE0: vector low byte of IRQ channel 0 in vectored mode.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sync`  in  1  high for the cycle whose rising edge begins an opcode fetch or exception sequence (the core's `next_sync`).
- `i_flag`  in  1  SR I bit; 1 masks all IRQ channels.
- `nmi_n`  in  1  NMI pin, falling-edge triggered; synchronous to `clk`.
- `irq_n`  in  NUM_IRQ  IRQ pins, active-low; synchronous to `clk`.
- `irq_en`  in  NUM_IRQ  per-channel enable; 0 blocks the channel from being taken but not from latching.
- `rst`  out  1  reset sequence selected.
- `nmi`  out  1  NMI sequence selected.
- `irq`  out  1  IRQ sequence selected.
- `irq_id`  out  3  channel being serviced; valid while `irq`=1, otherwise 0.
- `fi`  out  8  vector low byte.
- `irq_pending`  out  NUM_IRQ  per-channel pending status, before masking.

## Operation
- States: RESET, IDLE, TAKE_NMI, TAKE_IRQ. Outputs decode directly from state registers:
  - RESET: `rst`=1.
  - TAKE_NMI: `nmi`=1.
  - TAKE_IRQ: `irq`=1.
  - IDLE: all three qualifiers 0.
- `fi` encoding:
  - RESET: 8'hFC.
  - TAKE_NMI: 8'hFA.
  - Otherwise: 8'hFE, or the vectored value (see Configuration).
- Reset (rst_n=0, asynchronous):
  - State forced to RESET; `rst_armed` cleared.
  - All latches cleared; edge-history registers set to 1.
  - Outputs: `rst`=1, `nmi`=0, `irq`=0, `irq_id`=0, `fi`=8'hFC, `irq_pending`=0.
- Edge detection:
  - `nmi_n` and each edge channel are registered every cycle.
  - A falling edge is a sample of 0 whose previous sample was 1.
  - A falling edge sets the corresponding latch.
- Pending:
  - Edge channel n: pending = its latch.
  - Level channel n: pending = ~irq_n[n], no latch.
- Eligible IRQ = pending & `irq_en` & ~`i_flag`. Among eligible channels, lowest index wins.
- Decision: on a rising edge with `sync`=1, the next state is the first match in this order:
  1. RESET, if state is RESET and `rst_armed`=0; `rst_armed` is set at the same edge.
  2. TAKE_NMI, if the NMI latch is set; the NMI latch is cleared.
  3. TAKE_IRQ, if any IRQ is eligible; `irq_id` is loaded, and the winning channel's latch is cleared if it is an edge channel.
  4. IDLE.
- The selected state holds until the next `sync` edge, which ends the exception sequence.
- Simultaneous latch set and clear on one edge: the set wins, so a new edge is never lost.
- Level channel released before it is taken: it is no longer pending and is not serviced.
- `i_flag` does not affect NMI.

## Timing
- Pin falling before rising edge k sets the latch at edge k. The earliest edge that can take it is the first `sync` edge at or after k+1.
- The decision and the outputs register at the same `sync` edge, so outputs are stable for the whole following sequence.
- Reset release: `rst` stays 1 through the first post-reset `sync` edge and the sequence that follows. Normal arbitration starts at the second `sync` edge.
- `rst_n` asserted mid-sequence aborts at once: outputs take their reset values asynchronously and pending edges are discarded.

## Configuration
- `K6502_IRQ_VECTORED_EN` defined: in TAKE_IRQ, `fi` = `IRQ_VEC_BASE` + 2·`irq_id`, modulo 256.
- Not defined: in TAKE_IRQ, `fi` = 8'hFE for every channel. `irq_id` is still driven so software can poll it.

## Test plan
- Reset: hold rst_n=0 with random pins; release; pulse `sync` twice.
  - Required: `rst`=1, `fi`=8'hFC through the first sync sequence; IDLE with `fi`=8'hFE after the second.
- NMI vs IRQ: nmi_n falls and level irq_n[2]=0 in the same cycle, i_flag=0, irq_en=4'hF; sync.
  - Required: first sync takes NMI (`fi`=8'hFA).
  - Required: next sync takes IRQ, `irq_id`=2.
- Masking: level irq_n[0]=0 held with i_flag=1 across three syncs.
  - Required: `irq`=0 and `irq_pending`[0]=1 throughout.
  - Then i_flag=0: the next sync gives `irq`=1, `irq_id`=0.
- Edge latch and priority: IRQ_EDGE=4'b1000; pulse irq_n[3] low for 1 cycle, then irq_n[1] level low; sync.
  - Required: channel 1 taken first.
  - Required: channel 3 taken at the following sync even though its pin has returned high.
  - Vectored build: `fi`=8'hE2, then 8'hE6.
- Set/clear collision: edge channel 3 falls on the same edge that takes channel 3.
  - Required: `irq_pending`[3] remains 1; serviced again at the next sync.
- Reset mid-service: assert rst_n=0 while `nmi`=1.
  - Required: `nmi`=0, `rst`=1, `fi`=8'hFC immediately, with no clock edge needed.

Source files
------------

// File: rtl/k6502_int_ctrl.sv
// k6502_int_ctrl: reset/NMI/multi-channel IRQ sequencer for the k6502 core.
// At every opcode-fetch boundary (sync) it picks the next exception by fixed
// priority: reset, NMI, then the lowest-numbered eligible IRQ channel.
// IRQ channels are individually edge (falling) or level (active-low) sensitive.
// Optional feature macro: K6502_IRQ_VECTORED_EN gives every IRQ channel its own
// vector low byte (IRQ_VEC_BASE + 2*irq_id); without it all channels use 8'hFE.
module k6502_int_ctrl #(
    parameter int               NUM_IRQ      = 4,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE   = '0,
    parameter logic [7:0]       IRQ_VEC_BASE = 8'hE0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync,
    input  logic               i_flag,
    input  logic               nmi_n,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic [NUM_IRQ-1:0] irq_en,
    output logic               rst,
    output logic               nmi,
    output logic               irq,
    output logic [2:0]         irq_id,
    output logic [7:0]         fi,
    output logic [NUM_IRQ-1:0] irq_pending
);

    typedef enum logic [1:0] {
        ST_RESET    = 2'd0,
        ST_IDLE     = 2'd1,
        ST_TAKE_NMI = 2'd2,
        ST_TAKE_IRQ = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               rst_armed_q, rst_armed_d;
    logic               nmi_prev_q;
    logic               nmi_lat_q, nmi_lat_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] irq_lat_q, irq_lat_d;
    logic [2:0]         irq_id_q, irq_id_d;

    logic               nmi_fall;
    logic               nmi_clr;
    logic [NUM_IRQ-1:0] irq_fall;
    logic [NUM_IRQ-1:0] irq_clr;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;
    logic               any_eligible;
    logic [2:0]         win_id;

    // Falling-edge detection against the previous sample; level channels never latch.
    always_comb begin
        nmi_fall = nmi_prev_q & ~nmi_n;
        irq_fall = IRQ_EDGE & irq_prev_q & ~irq_n;
        pending  = (IRQ_EDGE & irq_lat_q) | (~IRQ_EDGE & ~irq_n);
        eligible = pending & irq_en & {NUM_IRQ{~i_flag}};
    end

    // Lowest-index eligible channel wins; scan from the top so the last hit is the lowest.
    always_comb begin
        win_id       = 3'd0;
        any_eligible = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id       = 3'(i);
                any_eligible = 1'b1;
            end
        end
    end

    // Exception arbitration at the sync edge; the state holds between sync edges.
    always_comb begin
        state_d     = state_q;
        rst_armed_d = rst_armed_q;
        irq_id_d    = irq_id_q;
        nmi_clr     = 1'b0;
        irq_clr     = '0;
        if (sync) begin
            if (state_q == ST_RESET && !rst_armed_q) begin
                // First sync after reset replays the reset sequence itself.
                state_d     = ST_RESET;
                rst_armed_d = 1'b1;
                irq_id_d    = 3'd0;
            end else if (nmi_lat_q) begin
                state_d  = ST_TAKE_NMI;
                nmi_clr  = 1'b1;
                irq_id_d = 3'd0;
            end else if (any_eligible) begin
                state_d  = ST_TAKE_IRQ;
                irq_id_d = win_id;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    irq_clr[i] = IRQ_EDGE[i] && (win_id == 3'(i));
                end
            end else begin
                state_d  = ST_IDLE;
                irq_id_d = 3'd0;
            end
        end
        // A new edge arriving on the clearing edge wins, so it is never lost.
        nmi_lat_d = (nmi_lat_q & ~nmi_clr) | nmi_fall;
        irq_lat_d = (irq_lat_q & ~irq_clr) | irq_fall;
    end

    // All sequencer state: FSM, reset arming, latches and edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            rst_armed_q <= 1'b0;
            nmi_prev_q  <= 1'b1;
            nmi_lat_q   <= 1'b0;
            irq_prev_q  <= '1;
            irq_lat_q   <= '0;
            irq_id_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            rst_armed_q <= rst_armed_d;
            nmi_prev_q  <= nmi_n;
            nmi_lat_q   <= nmi_lat_d;
            irq_prev_q  <= irq_n;
            irq_lat_q   <= irq_lat_d;
            irq_id_q    <= irq_id_d;
        end
    end

    // Qualifiers and vector byte decode straight from the state registers.
    always_comb begin
        rst    = (state_q == ST_RESET);
        nmi    = (state_q == ST_TAKE_NMI);
        irq    = (state_q == ST_TAKE_IRQ);
        irq_id = irq_id_q;
        case (state_q)
            ST_RESET:    fi = 8'hFC;
            ST_TAKE_NMI: fi = 8'hFA;
`ifdef K6502_IRQ_VECTORED_EN
            ST_TAKE_IRQ: fi = IRQ_VEC_BASE + {4'b0000, irq_id_q, 1'b0};
`else
            ST_TAKE_IRQ: fi = 8'hFE;
`endif
            default:     fi = 8'hFE;
        endcase
        // Level channels follow the pins, so status is forced clear while in reset.
        irq_pending = rst_n ? pending : '0;
    end

endmodule

// File: tb/tb_k6502_int_ctrl.sv
// Bench for k6502_int_ctrl: directed scenarios then randomized traffic, all
// checked against a behavioural model of the exception-selection rules.
module tb_k6502_int_ctrl;

    localparam int         NUM_IRQ  = 4;
    localparam logic [3:0] IRQ_EDGE = 4'b1000;
    localparam logic [7:0] VEC_BASE = 8'hE0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sync;
    logic       i_flag;
    logic       nmi_n;
    logic [3:0] irq_n;
    logic [3:0] irq_en;
    logic       rst;
    logic       nmi;
    logic       irq;
    logic [2:0] irq_id;
    logic [7:0] fi;
    logic [3:0] irq_pending;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: which sequence is selected and what is remembered.
    bit m_rst, m_nmi, m_irq, m_armed;
    int m_id;
    bit m_nmi_lat, m_nmi_prev;
    bit m_lat  [4];
    bit m_prev [4];

    k6502_int_ctrl #(
        .NUM_IRQ      (NUM_IRQ),
        .IRQ_EDGE     (IRQ_EDGE),
        .IRQ_VEC_BASE (VEC_BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync        (sync),
        .i_flag      (i_flag),
        .nmi_n       (nmi_n),
        .irq_n       (irq_n),
        .irq_en      (irq_en),
        .rst         (rst),
        .nmi         (nmi),
        .irq         (irq),
        .irq_id      (irq_id),
        .fi          (fi),
        .irq_pending (irq_pending)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_rst = 1; m_nmi = 0; m_irq = 0; m_armed = 0; m_id = 0;
        m_nmi_lat = 0; m_nmi_prev = 1;
        for (int i = 0; i < 4; i++) begin
            m_lat[i]  = 0;
            m_prev[i] = 1;
        end
    endtask

    function automatic bit chan_pending(input int i);
        return IRQ_EDGE[i] ? m_lat[i] : !irq_n[i];
    endfunction

    // One rising edge of the model, using the pins as they stand before the edge.
    task automatic model_edge();
        bit nfall;
        bit falls [4];
        int win;
        nfall = m_nmi_prev && !nmi_n;
        for (int i = 0; i < 4; i++) falls[i] = IRQ_EDGE[i] && m_prev[i] && !irq_n[i];
        if (sync) begin
            win = -1;
            if (!i_flag)
                for (int i = 3; i >= 0; i--)
                    if (chan_pending(i) && irq_en[i]) win = i;
            if (m_rst && !m_armed) begin
                m_armed = 1;
            end else begin
                m_rst = 0; m_nmi = 0; m_irq = 0; m_id = 0;
                if (m_nmi_lat) begin
                    m_nmi = 1;
                    m_nmi_lat = 0;
                end else if (win >= 0) begin
                    m_irq = 1;
                    m_id  = win;
                    if (IRQ_EDGE[win]) m_lat[win] = 0;
                end
            end
        end
        if (nfall) m_nmi_lat = 1;
        for (int i = 0; i < 4; i++) if (falls[i]) m_lat[i] = 1;
        m_nmi_prev = nmi_n;
        for (int i = 0; i < 4; i++) m_prev[i] = irq_n[i];
    endtask

    function automatic logic [7:0] exp_fi();
        if (m_rst) return 8'hFC;
        if (m_nmi) return 8'hFA;
`ifdef K6502_IRQ_VECTORED_EN
        if (m_irq) return 8'((int'(VEC_BASE) + 2 * m_id) % 256);
`endif
        return 8'hFE;
    endfunction

    function automatic logic [3:0] exp_pending();
        logic [3:0] p;
        p = '0;
        if (rst_n)
            for (int i = 0; i < 4; i++) p[i] = chan_pending(i);
        return p;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("rst",         8'(rst),         8'(m_rst));
        check("nmi",         8'(nmi),         8'(m_nmi));
        check("irq",         8'(irq),         8'(m_irq));
        check("irq_id",      8'(irq_id),      8'(m_id));
        check("fi",          fi,              exp_fi());
        check("irq_pending", 8'(irq_pending), 8'(exp_pending()));
    endtask

    // Advance one clock with the given sync value and compare after the edge.
    task automatic tick(input bit s);
        sync = s;
        if (rst_n) model_edge();
        else       model_reset();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // Reset held with random pins, then released with quiet pins.
        rst_n  = 1'b0;
        sync   = 1'b0;
        i_flag = 1'($urandom);
        nmi_n  = 1'($urandom);
        irq_n  = 4'($urandom);
        irq_en = 4'($urandom);
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < 3; i++) begin
            nmi_n  = 1'($urandom);
            irq_n  = 4'($urandom);
            i_flag = 1'($urandom);
            tick(1'($urandom));
        end
        nmi_n = 1'b1; irq_n = 4'hF; irq_en = 4'hF; i_flag = 1'b0;
        tick(0);
        rst_n = 1'b1;
        tick(0);
        tick(1);
        tick(0);
        tick(1);

        // NMI and level IRQ arrive together: NMI first, then channel 2.
        nmi_n = 1'b0; irq_n[2] = 1'b0;
        tick(0);
        nmi_n = 1'b1;
        tick(1);
        tick(0);
        tick(1);
        irq_n[2] = 1'b1;
        tick(1);

        // Masked level channel 0 stays pending but is not taken until i_flag drops.
        irq_n[0] = 1'b0; i_flag = 1'b1;
        tick(1);
        tick(1);
        tick(1);
        i_flag = 1'b0;
        tick(1);
        irq_n[0] = 1'b1;
        tick(1);

        // Edge channel 3 pulsed, level channel 1 held: 1 first, then latched 3.
        irq_n[3] = 1'b0;
        tick(0);
        irq_n[3] = 1'b1; irq_n[1] = 1'b0;
        tick(0);
        tick(1);
        irq_n[1] = 1'b1;
        tick(1);
        tick(1);

        // New edge on channel 3 at the very edge that services it.
        irq_n[3] = 1'b0;
        tick(0);
        irq_n[3] = 1'b1;
        tick(0);
        irq_n[3] = 1'b0;
        tick(1);
        irq_n[3] = 1'b1;
        tick(1);
        tick(1);

        // Reset asserted while NMI is being serviced takes effect without a clock.
        nmi_n = 1'b0;
        tick(0);
        nmi_n = 1'b1;
        tick(1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        tick(0);
        rst_n = 1'b1;
        tick(1);
        tick(1);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            if (!rst_n && $urandom_range(0, 3) == 0) rst_n = 1'b1;
            nmi_n  = ($urandom_range(0, 9) != 0);
            irq_n  = 4'($urandom) | 4'($urandom);
            i_flag = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) irq_en = 4'($urandom);
            tick($urandom_range(0, 2) == 0);
            if (rst_n && $urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #2;
                check_all();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
